// File: rtl/frame_dump_pkg.sv
// Shared types and the dump-window helper for the frame dump controller.
// The optional LED tracking feature is enabled with the FRAME_DUMP_LED_EN macro.
package frame_dump_pkg;

    localparam int CNT_W     = 32;
    localparam int LED_CNT_W = 16;

    typedef logic [CNT_W-1:0] frame_cnt_t;

    // The window end is formed at CNT_W+1 bits so start+len cannot wrap.
    function automatic logic in_window(frame_cnt_t cnt, frame_cnt_t start, frame_cnt_t len);
        logic [CNT_W:0] win_end;
        win_end = {1'b0, start} + {1'b0, len};
        return (cnt >= start) && ((len == '0) || ({1'b0, cnt} < win_end));
    endfunction

endpackage

// File: rtl/vs_edge_det.sv
// Vertical-blank edge detector: polarity normalisation and a single-cycle
// pulse on the start of each active blank.
module vs_edge_det #(
    parameter bit VS_POL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vs,
    output logic fe
);

    logic vs_i;
    logic vs_l_reg;

    assign vs_i = VS_POL ? vs : ~vs;

    // History resets high so a blank already active at reset release is not counted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_l_reg <= 1'b1;
        end else begin
            vs_l_reg <= vs_i;
        end
    end

    assign fe = vs_i & ~vs_l_reg;

endmodule

// File: rtl/frame_dump_ctrl.sv
// Frame counter with a waveform-dump window and sticky end-of-run flag.
// Define FRAME_DUMP_LED_EN to add the led_frame / led_toggles status outputs.
module frame_dump_ctrl
    import frame_dump_pkg::*;
#(
    parameter logic [31:0] DUMP_START = 32'd0,
    parameter logic [31:0] DUMP_LEN   = 32'd0,
    parameter logic [31:0] MAX_FRAMES = 32'd0,
    parameter bit          VS_POL     = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 vs,
    input  logic                 led,
    output logic [CNT_W-1:0]     frame_cnt,
    output logic                 dump_en,
    output logic                 finish
`ifdef FRAME_DUMP_LED_EN
    ,
    output logic                 led_frame,
    output logic [LED_CNT_W-1:0] led_toggles
`endif
);

    logic       fe;
    frame_cnt_t frame_cnt_reg;
    logic       dump_en_reg;
    logic       finish_reg;

    vs_edge_det #(
        .VS_POL (VS_POL)
    ) u_vs_edge_det (
        .clk   (clk),
        .rst_n (rst_n),
        .vs    (vs),
        .fe    (fe)
    );

    // dump_en and finish look at the current count, so they trail it by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_reg <= '0;
            dump_en_reg   <= 1'b0;
            finish_reg    <= 1'b0;
        end else begin
            if (fe && !finish_reg && (frame_cnt_reg != '1)) begin
                frame_cnt_reg <= frame_cnt_reg + frame_cnt_t'(1);
            end
            dump_en_reg <= in_window(frame_cnt_reg, DUMP_START, DUMP_LEN);
            finish_reg  <= finish_reg | ((MAX_FRAMES != '0) && (frame_cnt_reg == MAX_FRAMES));
        end
    end

    assign frame_cnt = frame_cnt_reg;
    assign dump_en   = dump_en_reg;
    assign finish    = finish_reg;

`ifdef FRAME_DUMP_LED_EN
    logic                 led_l_reg;
    logic                 led_frame_reg;
    logic [LED_CNT_W-1:0] led_toggles_reg;

    // led history keeps tracking after finish; only the published values freeze.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led_l_reg       <= 1'b0;
            led_frame_reg   <= 1'b0;
            led_toggles_reg <= '0;
        end else begin
            led_l_reg <= led;
            if (!finish_reg) begin
                if (fe) begin
                    led_frame_reg <= led;
                end
                if ((led != led_l_reg) && (led_toggles_reg != '1)) begin
                    led_toggles_reg <= led_toggles_reg + LED_CNT_W'(1);
                end
            end
        end
    end

    assign led_frame   = led_frame_reg;
    assign led_toggles = led_toggles_reg;
`else
    logic unused_led;
    assign unused_led = led;
`endif

endmodule

// File: tb/tb_frame_dump_ctrl.sv
// Scoreboard bench for frame_dump_ctrl: two instances (active-high vs with a
// bounded window and end frame, active-low vs with defaults) under random vs/led/reset.
module tb_frame_dump_ctrl;

    localparam longint A_START = 3;
    localparam longint A_LEN   = 2;
    localparam longint A_MAX   = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vs_a, vs_b, led;
    logic [31:0] frame_cnt_a, frame_cnt_b;
    logic        dump_en_a, dump_en_b, finish_a, finish_b;
`ifdef FRAME_DUMP_LED_EN
    logic        led_frame_a, led_frame_b;
    logic [15:0] led_toggles_a, led_toggles_b;
`endif

    always #5 clk = ~clk;

    frame_dump_ctrl #(
        .DUMP_START (32'd3),
        .DUMP_LEN   (32'd2),
        .MAX_FRAMES (32'd10),
        .VS_POL     (1'b1)
    ) u_dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .vs          (vs_a),
        .led         (led),
        .frame_cnt   (frame_cnt_a),
        .dump_en     (dump_en_a),
        .finish      (finish_a)
`ifdef FRAME_DUMP_LED_EN
        ,
        .led_frame   (led_frame_a),
        .led_toggles (led_toggles_a)
`endif
    );

    frame_dump_ctrl #(
        .DUMP_START (32'd0),
        .DUMP_LEN   (32'd0),
        .MAX_FRAMES (32'd0),
        .VS_POL     (1'b0)
    ) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .vs          (vs_b),
        .led         (led),
        .frame_cnt   (frame_cnt_b),
        .dump_en     (dump_en_b),
        .finish      (finish_b)
`ifdef FRAME_DUMP_LED_EN
        ,
        .led_frame   (led_frame_b),
        .led_toggles (led_toggles_b)
`endif
    );

    // Reference state: what an observer would see after each clock edge.
    typedef struct {
        longint cnt;
        bit     dump;
        bit     fin;
        bit     blank_prev;
        bit     led_prev;
        bit     led_frame;
        longint toggles;
    } mstate_t;

    typedef struct {
        mstate_t a;
        mstate_t b;
    } exp_t;

    mstate_t model_a, model_b;
    exp_t    exp_q[$];
    int      n_checks = 0;
    int      n_fail   = 0;

    function automatic mstate_t reset_state();
        mstate_t s;
        s.cnt        = 0;
        s.dump       = 1'b0;
        s.fin        = 1'b0;
        s.blank_prev = 1'b1;
        s.led_prev   = 1'b0;
        s.led_frame  = 1'b0;
        s.toggles    = 0;
        return s;
    endfunction

    // One clock edge of behaviour, written from the frame/window rules.
    function automatic mstate_t model_step(mstate_t s, bit rst, bit blank, bit led_v,
                                           longint start, longint len, longint maxf);
        mstate_t n;
        bit      new_frame;
        if (!rst) return reset_state();
        n = s;
        new_frame    = blank && !s.blank_prev;
        n.blank_prev = blank;
        n.led_prev   = led_v;
        if (new_frame && !s.fin && s.cnt < 64'h0000_0000_FFFF_FFFF) n.cnt = s.cnt + 1;
        n.dump = (s.cnt >= start) && (len == 0 || s.cnt < start + len);
        n.fin  = s.fin || (maxf != 0 && s.cnt == maxf);
        if (!s.fin) begin
            if (new_frame) n.led_frame = led_v;
            if (led_v != s.led_prev && s.toggles < 65535) n.toggles = s.toggles + 1;
        end
        return n;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply the currently set inputs for one clock and queue the expected result.
    task automatic step();
        exp_t e;
        model_a = model_step(model_a, rst_n, vs_a, led, A_START, A_LEN, A_MAX);
        model_b = model_step(model_b, rst_n, ~vs_b, led, 0, 0, 0);
        e.a = model_a;
        e.b = model_b;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: the design presents a new state every clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("a.frame_cnt", longint'(frame_cnt_a), e.a.cnt);
                check("a.dump_en",   longint'(dump_en_a),   longint'(e.a.dump));
                check("a.finish",    longint'(finish_a),    longint'(e.a.fin));
                check("b.frame_cnt", longint'(frame_cnt_b), e.b.cnt);
                check("b.dump_en",   longint'(dump_en_b),   longint'(e.b.dump));
                check("b.finish",    longint'(finish_b),    longint'(e.b.fin));
`ifdef FRAME_DUMP_LED_EN
                check("a.led_frame",   longint'(led_frame_a),   longint'(e.a.led_frame));
                check("a.led_toggles", longint'(led_toggles_a), e.a.toggles);
                check("b.led_frame",   longint'(led_frame_b),   longint'(e.b.led_frame));
                check("b.led_toggles", longint'(led_toggles_b), e.b.toggles);
`endif
                $display("cyc t=%0t rst_n=%0b vs_a=%0b vs_b=%0b led=%0b | a cnt=%0d dump=%0b fin=%0b | b cnt=%0d dump=%0b fin=%0b",
                         $time, rst_n, vs_a, vs_b, led, frame_cnt_a, dump_en_a, finish_a,
                         frame_cnt_b, dump_en_b, finish_b);
            end
        end
    end

    task automatic random_phase(input int cycles, input int reset_odds);
        for (int i = 0; i < cycles; i++) begin
            if ($urandom_range(3) == 0) vs_a = ~vs_a;
            if ($urandom_range(3) == 0) vs_b = ~vs_b;
            if ($urandom_range(4) == 0) led = ~led;
            rst_n = (reset_odds == 0) ? 1'b1 : ($urandom_range(reset_odds - 1) != 0);
            step();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        model_a = reset_state();
        model_b = reset_state();
        rst_n = 1'b0;
        vs_a  = 1'b0;
        vs_b  = 1'b1;
        led   = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;

        // Five clean frames on both polarities, led toggled between frames.
        for (int i = 0; i < 5; i++) begin
            vs_a = 1'b1;
            vs_b = 1'b0;
            step();
            vs_a = 1'b0;
            vs_b = 1'b1;
            step();
            led = ~led;
            repeat (2) step();
        end

        // Run A past its end frame, then reset with blank active through release.
        random_phase(300, 0);
        vs_a  = 1'b1;
        vs_b  = 1'b0;
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (20) step();

        // One-cycle glitches are valid frames.
        for (int i = 0; i < 6; i++) begin
            vs_a = 1'b0;
            vs_b = 1'b1;
            step();
            vs_a = 1'b1;
            vs_b = 1'b0;
            step();
        end

        random_phase(800, 120);
        random_phase(200, 0);

        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected states left unchecked, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
